// File: rtl/snn_frame_sequencer_if.sv
// rtl/snn_frame_sequencer_if.sv - byte stream from the frame sequencer to the UART transmitter
interface snn_frame_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/snn_frame_sequencer.sv
// rtl/snn_frame_sequencer.sv - per-frame timestep ticks, spike-count snapshot and result streaming
// Optional argmax result scan: SNN_FRAME_ARGMAX_EN
module snn_frame_sequencer #(
    parameter int         NUM_CH   = 10,
    parameter int         CNT_W    = 8,
    parameter int         TIME_W   = 16,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                    i_snn_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [TIME_W-1:0]       i_process_time,
    input  logic [TIME_W-1:0]       i_all_time,
    input  logic [TIME_W-1:0]       i_tick_period,
    input  logic                    i_ext_tick,
    input  logic [NUM_CH*CNT_W-1:0] i_counters_flat,
    input  logic [7:0]              i_result_num,
    snn_frame_sequencer_if.master   tx,
    output logic                    o_timestep_tick,
    output logic                    o_leak_phase,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic [7:0]              o_winner
);
    localparam int STEP_W = TIME_W + 1;
    localparam int IDX_W  = $clog2(NUM_CH + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH + 1);
    localparam logic [IDX_W-1:0] RES_IDX  = IDX_W'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LEAK, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [STEP_W-1:0] r_p;
    logic [STEP_W-1:0] r_a_plus1;
    logic [TIME_W-1:0] r_period_m1;
    logic [TIME_W-1:0] r_div;
    logic [STEP_W-1:0] r_step;
    logic [7:0]        r_snap [NUM_CH];
    logic [IDX_W-1:0]  r_idx;
    logic              r_load;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_tick;
    logic              r_leak;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_winner;

    logic              w_tick_req;
    logic              w_snapshot;
    logic              w_done;
    logic              w_send_done;
    logic [STEP_W-1:0] w_step_inc;
    logic [TIME_W-1:0] w_p_eff;
    logic [TIME_W-1:0] w_a_eff;
    logic [7:0]        w_snap_sel;
    logic [7:0]        w_result;

    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
        logic [CNT_W+7:0] e;
        e = {8'b0, v};
        return (e[CNT_W+7:8] != '0) ? 8'hFF : e[7:0];
    endfunction

    always_ff @(posedge i_snn_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_snapshot  = 1'b0;
        w_done      = 1'b0;
        w_tick_req  = 1'b0;
        w_step_inc  = r_step + STEP_W'(1);
        w_p_eff     = (i_process_time == '0) ? TIME_W'(1) : i_process_time;
        w_a_eff     = (i_all_time < w_p_eff) ? w_p_eff : i_all_time;
        // A byte still being presented only counts as done if it transfers this cycle
        w_send_done = !r_load && (!r_tx_valid || (tx.tx_ready && r_idx == LAST_IDX));
        if (r_state == S_RUN || r_state == S_LEAK)
            w_tick_req = (r_div == '0) || (r_state == S_RUN && i_ext_tick);
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_next = S_RUN;
                S_RUN:   if (w_tick_req && w_step_inc == r_p) begin
                             w_next     = S_LEAK;
                             w_snapshot = 1'b1;
                         end
                S_LEAK:  if (w_tick_req && w_step_inc == r_a_plus1) w_next = S_DRAIN;
                S_DRAIN: if (w_send_done) begin
                             w_next = S_IDLE;
                             w_done = 1'b1;
                         end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_snap_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (r_idx == IDX_W'(i)) w_snap_sel = r_snap[i];
    end

    always_ff @(posedge i_snn_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p         <= '0;
            r_a_plus1   <= '0;
            r_period_m1 <= '0;
            r_div       <= '0;
            r_step      <= '0;
            for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
            r_idx       <= '0;
            r_load      <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_tick      <= 1'b0;
            r_leak      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_winner    <= '0;
        end else begin
            r_tick <= w_tick_req && !i_abort;
            r_leak <= (w_next == S_LEAK) || (w_next == S_DRAIN);
            r_busy <= (w_next != S_IDLE);
            r_done <= w_done;

            if (r_state == S_IDLE) begin
                if (w_next == S_RUN) begin
                    r_p         <= {1'b0, w_p_eff};
                    r_a_plus1   <= {1'b0, w_a_eff} + STEP_W'(1);
                    r_period_m1 <= (i_tick_period == '0) ? '0 : i_tick_period - TIME_W'(1);
                    r_div       <= '0;
                    r_step      <= '0;
                end
            end else if (r_state == S_RUN || r_state == S_LEAK) begin
                // Any tick (free-running or ext) restarts the period count
                if (w_tick_req) begin
                    r_step <= w_step_inc;
                    r_div  <= (r_period_m1 == '0) ? '0 : TIME_W'(1);
                end else begin
                    r_div  <= (r_div == r_period_m1) ? '0 : r_div + TIME_W'(1);
                end
            end

            if (i_abort) begin
                r_load     <= 1'b0;
                r_tx_valid <= 1'b0;
            end else if (w_snapshot) begin
                for (int i = 0; i < NUM_CH; i++)
                    r_snap[i] <= sat8(i_counters_flat[i*CNT_W +: CNT_W]);
                r_idx  <= '0;
                r_load <= 1'b1;
            end else if (r_load) begin
                r_load     <= 1'b0;
                r_tx_valid <= 1'b1;
                r_tx_data  <= HDR_BYTE;
            end else if (r_tx_valid && tx.tx_ready) begin
                if (r_idx == LAST_IDX) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == RES_IDX) begin
                        r_tx_data <= w_result;
                        r_winner  <= w_result;
                    end else begin
                        r_tx_data <= w_snap_sel;
                    end
                end
            end
        end
    end

`ifdef SNN_FRAME_ARGMAX_EN
    localparam int SCAN_W = $clog2(NUM_CH);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_CH - 1);

    logic              r_scan_on;
    logic [SCAN_W-1:0] r_scan_idx;
    logic [7:0]        r_best_val;
    logic [7:0]        r_best_idx;
    logic [7:0]        w_scan_val;

    always_comb begin
        w_scan_val = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (r_scan_idx == SCAN_W'(i)) w_scan_val = r_snap[i];
    end

    // Strict compare keeps the lowest index on ties; an all-zero bank leaves 8'hFF
    always_ff @(posedge i_snn_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scan_on  <= 1'b0;
            r_scan_idx <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (i_abort) begin
            r_scan_on  <= 1'b0;
        end else if (w_snapshot) begin
            r_scan_on  <= 1'b1;
            r_scan_idx <= '0;
            r_best_val <= '0;
            r_best_idx <= 8'hFF;
        end else if (r_scan_on) begin
            if (w_scan_val > r_best_val) begin
                r_best_val <= w_scan_val;
                r_best_idx <= 8'(r_scan_idx);
            end
            if (r_scan_idx == SCAN_LAST) r_scan_on  <= 1'b0;
            else                         r_scan_idx <= r_scan_idx + SCAN_W'(1);
        end
    end

    assign w_result = r_best_idx;
`else
    logic [7:0] r_result;

    always_ff @(posedge i_snn_clk or posedge i_rst) begin
        if (i_rst)           r_result <= '0;
        else if (w_snapshot) r_result <= i_result_num;
    end

    assign w_result = r_result;
`endif

    assign tx.tx_data      = r_tx_data;
    assign tx.tx_valid     = r_tx_valid;
    assign o_timestep_tick = r_tick;
    assign o_leak_phase    = r_leak;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_done;
    assign o_winner        = r_winner;
endmodule

// File: tb/tb_snn_frame_sequencer.sv
// tb/tb_snn_frame_sequencer.sv - self-checking bench for snn_frame_sequencer
module tb_snn_frame_sequencer;
    localparam int NCH = 10;
    localparam int CW  = 10;
    localparam int TW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort, ext_tick;
    logic [TW-1:0]     process_time, all_time, tick_period;
    logic [NCH*CW-1:0] counters;
    logic [7:0]        result_num;
    logic              o_tick, o_leak, o_busy, o_done;
    logic [7:0]        o_winner;

    snn_frame_sequencer_if tx_if();

    snn_frame_sequencer #(.NUM_CH(NCH), .CNT_W(CW), .TIME_W(TW), .HDR_BYTE(8'hA5)) dut (
        .i_snn_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_process_time(process_time), .i_all_time(all_time), .i_tick_period(tick_period),
        .i_ext_tick(ext_tick), .i_counters_flat(counters), .i_result_num(result_num),
        .tx(tx_if.master),
        .o_timestep_tick(o_tick), .o_leak_phase(o_leak), .o_busy(o_busy),
        .o_frame_done(o_done), .o_winner(o_winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p, a, per;
        logic [NCH*CW-1:0] cnts;
        logic [7:0] rn;
        int n_ticks, per_eff, leak, first_byte, done;
        logic [7:0] res_sel, res_max;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int         q_tick[$];
    logic [7:0] q_byte[$];
    int         q_bcyc[$];
    int leak_cyc, done_cyc, done_cnt, abort_cyc, hold_err, stall_cnt, busy_seen;
    int post_busy, post_valid, post_leak, ticks_after_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*CW-1:0] pk(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
        int v[NCH];
        logic [NCH*CW-1:0] r;
        v = '{c0, c1, c2, c3, c4, c5, c6, c7, c8, c9};
        for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(v[i]);
        return r;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [NCH*CW-1:0] c, input int ch);
        logic [CW-1:0] v;
        v = c[ch*CW +: CW];
        return (v > 255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [7:0] pick_res(input vec_t v);
`ifdef SNN_FRAME_ARGMAX_EN
        return v.res_max;
`else
        return v.res_sel;
`endif
    endfunction

    task automatic run_frame(input int p, a, per, input logic [NCH*CW-1:0] cnts, input logic [7:0] rn,
                             input int stall_at, stall_len, input bit ext_mode, input int abort_at,
                             input int restart_at, input bit abort_start, input int max_cyc);
        logic       prev_valid, prev_ready, rdy;
        logic [7:0] prev_data;
        q_tick.delete(); q_byte.delete(); q_bcyc.delete();
        leak_cyc = -1; done_cyc = -1; done_cnt = 0; abort_cyc = -1; hold_err = 0; stall_cnt = 0;
        busy_seen = 0; post_busy = -1; post_valid = -1; post_leak = -1; ticks_after_abort = 0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0;
        @(negedge clk);
        process_time = TW'(p); all_time = TW'(a); tick_period = TW'(per);
        counters = cnts; result_num = rn; start = 1'b1; abort = abort_start; ext_tick = 1'b0;
        tx_if.tx_ready = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin
                process_time = 1; all_time = 1; tick_period = 1;
            end
            abort = 1'b0;
            ext_tick = ext_mode && (c % 2 == 0);
            if (o_tick) q_tick.push_back(c);
            if (o_leak && leak_cyc < 0) leak_cyc = c;
            if (o_done) begin done_cnt++; done_cyc = c; end
            if (o_busy) busy_seen = 1;
            if (abort_cyc >= 0 && c == abort_cyc + 1) begin
                post_busy = int'(o_busy); post_valid = int'(tx_if.tx_valid); post_leak = int'(o_leak);
            end
            if (abort_cyc >= 0 && c > abort_cyc && o_tick) ticks_after_abort++;
            if (prev_valid && !prev_ready && (!tx_if.tx_valid || tx_if.tx_data !== prev_data)) hold_err++;
            if (tx_if.tx_valid && q_byte.size() == abort_at && abort_cyc < 0) begin
                abort = 1'b1;
                abort_cyc = c;
            end
            rdy = !abort;
            if (tx_if.tx_valid && q_byte.size() == stall_at && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            tx_if.tx_ready = rdy;
            if (tx_if.tx_valid && rdy) begin
                q_byte.push_back(tx_if.tx_data);
                q_bcyc.push_back(c);
            end
            prev_valid = tx_if.tx_valid; prev_ready = rdy; prev_data = tx_if.tx_data;
            if (done_cnt > 0 && c >= done_cyc + 3) break;
            if (abort_cyc >= 0 && c >= abort_cyc + 20) break;
            if (abort_start && c >= 10) break;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; ext_tick = 1'b0; tx_if.tx_ready = 1'b1;
    endtask

    task automatic check_bytes(input string nm, input logic [NCH*CW-1:0] cnts, input logic [7:0] res);
        logic [7:0] eb[NCH+2];
        eb[0] = 8'hA5;
        for (int i = 0; i < NCH; i++) eb[i+1] = exp_byte(cnts, i);
        eb[NCH+1] = res;
        check({nm, "_nbytes"}, q_byte.size(), NCH + 2);
        for (int i = 0; i < NCH + 2; i++)
            if (i < q_byte.size()) check($sformatf("%s_byte%0d", nm, i), q_byte[i], eb[i]);
        check({nm, "_winner"}, o_winner, res);
    endtask

    task automatic check_frame(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", idx);
        check({nm, "_nticks"}, q_tick.size(), v.n_ticks);
        for (int k = 0; k < v.n_ticks; k++)
            if (k < q_tick.size()) check($sformatf("%s_tick%0d", nm, k), q_tick[k], 2 + k * v.per_eff);
        check({nm, "_leak"}, leak_cyc, v.leak);
        if (q_bcyc.size() > 0) begin
            check({nm, "_first_byte"}, q_bcyc[0], v.first_byte);
            check({nm, "_last_byte"}, q_bcyc[q_bcyc.size()-1], v.first_byte + NCH + 1);
        end
        check({nm, "_done_cyc"}, done_cyc, v.done);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_hold"}, hold_err, 0);
        check_bytes(nm, v.cnts, pick_res(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   exp_ext[6];
        logic [7:0] prev_win;

        tbl[0] = '{p:3, a:5, per:4, cnts:pk(3,9,9,1,0,0,0,0,0,0), rn:8'h07, n_ticks:6, per_eff:4,
                   leak:10, first_byte:11, done:23, res_sel:8'h07, res_max:8'h01};
        tbl[1] = '{p:0, a:0, per:1, cnts:'0, rn:8'h42, n_ticks:2, per_eff:1,
                   leak:2, first_byte:3, done:15, res_sel:8'h42, res_max:8'hFF};
        tbl[2] = '{p:2, a:2, per:0, cnts:pk(5,0,700,0,0,300,0,0,0,200), rn:8'h9C, n_ticks:3, per_eff:1,
                   leak:3, first_byte:4, done:16, res_sel:8'h9C, res_max:8'h02};
        tbl[3] = '{p:1, a:4, per:3, cnts:pk(0,20,40,60,80,100,120,140,160,180), rn:8'hE1, n_ticks:5,
                   per_eff:3, leak:2, first_byte:3, done:15, res_sel:8'hE1, res_max:8'h09};
        tbl[4] = '{p:5, a:2, per:2, cnts:pk(1,1,1,9,1,1,1,9,1,1), rn:8'h55, n_ticks:6, per_eff:2,
                   leak:10, first_byte:11, done:23, res_sel:8'h55, res_max:8'h03};

        rst = 1'b1; start = 1'b0; abort = 1'b0; ext_tick = 1'b0;
        process_time = '0; all_time = '0; tick_period = '0; counters = '0; result_num = '0;
        tx_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tick", o_tick, 0);
        check("rst_leak", o_leak, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_valid", tx_if.tx_valid, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_winner", o_winner, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].p, tbl[i].a, tbl[i].per, tbl[i].cnts, tbl[i].rn, -1, 0, 1'b0, -1, -1, 1'b0, 200);
            check_frame(i, tbl[i]);
            check($sformatf("v%0d_idle_after", i), o_busy, 0);
        end

        // Receiver stalls for 50 cycles while byte 4 is presented
        run_frame(3, 5, 4, tbl[0].cnts, 8'h07, 4, 50, 1'b0, -1, -1, 1'b0, 300);
        check("stall_cycles", stall_cnt, 50);
        check("stall_hold", hold_err, 0);
        check("stall_nticks", q_tick.size(), 6);
        if (q_tick.size() == 6) check("stall_last_tick", q_tick[5], 22);
        if (q_bcyc.size() == 12) begin
            check("stall_byte4_cyc", q_bcyc[4], 65);
            check("stall_last_cyc", q_bcyc[11], 72);
        end
        check("stall_done_cyc", done_cyc, 73);
        check("stall_done_cnt", done_cnt, 1);
        check_bytes("stall", tbl[0].cnts, pick_res(tbl[0]));

        // ext_tick every other cycle; honoured in RUN only
        exp_ext = '{2, 3, 5, 105, 205, 305};
        run_frame(3, 5, 100, tbl[3].cnts, 8'hE1, -1, 0, 1'b1, -1, -1, 1'b0, 400);
        check("ext_nticks", q_tick.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < q_tick.size()) check($sformatf("ext_tick%0d", k), q_tick[k], exp_ext[k]);
        check("ext_leak", leak_cyc, 5);
        check("ext_done_cyc", done_cyc, 306);
        if (q_bcyc.size() > 0) check("ext_first_byte", q_bcyc[0], 6);
        check_bytes("ext", tbl[3].cnts, pick_res(tbl[3]));

        // Abort while byte 5 is presented
        prev_win = pick_res(tbl[3]);
        run_frame(3, 5, 4, tbl[0].cnts, 8'h66, -1, 0, 1'b0, 5, -1, 1'b0, 200);
        check("abort_cyc", abort_cyc, 16);
        check("abort_busy", post_busy, 0);
        check("abort_valid", post_valid, 0);
        check("abort_leak", post_leak, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_ticks", ticks_after_abort, 0);
        check("abort_nbytes", q_byte.size(), 5);
        check("abort_winner", o_winner, prev_win);

        // abort together with start
        run_frame(3, 5, 4, tbl[0].cnts, 8'h07, -1, 0, 1'b0, -1, -1, 1'b1, 20);
        check("abst_busy", busy_seen, 0);
        check("abst_ticks", q_tick.size(), 0);

        // Second start mid-frame with different parameters
        run_frame(3, 5, 4, tbl[0].cnts, 8'h07, -1, 0, 1'b0, -1, 8, 1'b0, 200);
        check_frame(9, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
